// File: rtl/delay_line_prog.sv
// Multi-channel register delay line with run-time programmable depth (0..DN CE cycles).
// A valid bit travels with the data and is masked until the line has refilled.
module delay_line_prog #(
   parameter int SW       = 8,
   parameter int NCH      = 2,
   parameter int DN       = 16,
   parameter int DLY_INIT = 6,
   localparam int DW      = $clog2(DN + 1)
) (
   input  logic                Ck,
   input  logic                Rst,
   input  logic                CE,
   input  logic [NCH*SW-1:0]   DI,
   input  logic                VI,
   input  logic [DW-1:0]       Dly,
   input  logic                Dly_ld,
   input  logic                Flush,
   output logic [NCH*SW-1:0]   DO,
   output logic                VO,
   output logic                Rdy,
   output logic                Dly_err
);

   localparam logic [DW-1:0] DN_D   = DW'(DN);
   localparam logic [DW-1:0] INIT_D = DW'(DLY_INIT);

   logic [NCH*SW-1:0] sr_reg [DN];
   logic [DN-1:0]     vs_reg;
   logic [DW-1:0]     dly_reg;
   logic [DW-1:0]     cnt_reg;
   logic              err_reg;
   logic [NCH*SW-1:0] data_sel;
   logic              valid_sel;
   logic              rdy;

   // Each stage is its own register; flush clears only the valid bits.
   generate
      for (genvar gi = 0; gi < DN; gi++) begin : g_stage
         always_ff @(posedge Ck or posedge Rst) begin
            if (Rst) begin
               sr_reg[gi] <= '0;
               vs_reg[gi] <= 1'b0;
            end else begin
               if (CE) begin
                  if (gi == 0) begin
                     sr_reg[gi] <= DI;
                     vs_reg[gi] <= VI;
                  end else begin
                     sr_reg[gi] <= sr_reg[(gi == 0) ? 0 : gi - 1];
                     vs_reg[gi] <= vs_reg[(gi == 0) ? 0 : gi - 1];
                  end
               end
               if (Flush) begin
                  vs_reg[gi] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // A load or flush restarts the fill count; the edge that carries it is not counted.
   always_ff @(posedge Ck or posedge Rst) begin
      if (Rst) begin
         dly_reg <= INIT_D;
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         if (Dly_ld) begin
            dly_reg <= (Dly > DN_D) ? DN_D : Dly;
            if (Dly > DN_D) begin
               err_reg <= 1'b1;
            end
         end
         if (Dly_ld || Flush) begin
            cnt_reg <= '0;
         end else if (CE && (cnt_reg < dly_reg)) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      data_sel  = DI;
      valid_sel = VI;
      for (int k = 0; k < DN; k++) begin
         if (dly_reg == DW'(k + 1)) begin
            data_sel  = sr_reg[k];
            valid_sel = vs_reg[k];
         end
      end
   end

   assign rdy     = (cnt_reg == dly_reg);
   assign DO      = data_sel;
   assign VO      = valid_sel & rdy;
   assign Rdy     = rdy;
   assign Dly_err = err_reg;

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed bench for delay_line_prog: reset, fixed delay, CE gating, delay change,
// overrange load, flush, simultaneous flush/load and asynchronous reset.
module tb_delay_line_prog;

   localparam int SW = 8;
   localparam int NCH = 2;
   localparam int DN = 16;
   localparam int DLY_INIT = 6;
   localparam int DW = $clog2(DN + 1);

   logic                Ck;
   logic                Rst;
   logic                CE;
   logic [NCH*SW-1:0]   DI;
   logic                VI;
   logic [DW-1:0]       Dly;
   logic                Dly_ld;
   logic                Flush;
   logic [NCH*SW-1:0]   DO;
   logic                VO;
   logic                Rdy;
   logic                Dly_err;

   int checks = 0;
   int failures = 0;

   delay_line_prog #(
      .SW(SW), .NCH(NCH), .DN(DN), .DLY_INIT(DLY_INIT)
   ) dut (
      .Ck(Ck), .Rst(Rst), .CE(CE), .DI(DI), .VI(VI), .Dly(Dly),
      .Dly_ld(Dly_ld), .Flush(Flush), .DO(DO), .VO(VO), .Rdy(Rdy),
      .Dly_err(Dly_err)
   );

   initial Ck = 1'b0;
   always #5 Ck = ~Ck;

   // Channel 0 carries the ramp value, channel 1 the value offset by 0x80.
   function automatic logic [15:0] ramp(input int v);
      logic [7:0] b;
      b = 8'(v);
      return {b + 8'h80, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %s observed=%h expected=%h ok", tag, obs, exp);
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Ck);
      #1;
   endtask

   initial begin
      Rst = 1'b1; CE = 1'b0; DI = '0; VI = 1'b0;
      Dly = '0; Dly_ld = 1'b0; Flush = 1'b0;
      #1;
      chk("t1_async_do", 32'(DO), 32'h0);
      chk("t1_async_rdy", 32'(Rdy), 32'h0);

      // T1: reset held while inputs toggle
      for (int i = 0; i < 3; i++) begin
         DI = ramp(i * 37 + 5); CE = 1'b1; VI = 1'b1;
         tick();
         chk("t1_do", 32'(DO), 32'h0);
         chk("t1_vo", 32'(VO), 32'h0);
         chk("t1_rdy", 32'(Rdy), 32'h0);
         chk("t1_err", 32'(Dly_err), 32'h0);
      end
      Rst = 1'b0;

      // T2: default delay of 6, ramp 1,2,3..
      for (int k = 1; k <= 10; k++) begin
         DI = ramp(k); CE = 1'b1; VI = 1'b1;
         tick();
         if (k < 6) begin
            chk("t2_rdy_low", 32'(Rdy), 32'h0);
            chk("t2_vo_low", 32'(VO), 32'h0);
         end else begin
            chk("t2_rdy", 32'(Rdy), 32'h1);
            chk("t2_vo", 32'(VO), 32'h1);
            chk("t2_do", 32'(DO), 32'(ramp(k - 5)));
         end
      end

      // T3: delay 3 with CE alternating
      CE = 1'b0; Dly = 5'd3; Dly_ld = 1'b1;
      tick();
      Dly_ld = 1'b0;
      chk("t3_load_rdy", 32'(Rdy), 32'h0);
      chk("t3_load_vo", 32'(VO), 32'h0);
      for (int i = 0; i < 12; i++) begin
         CE = ((i % 2) == 0);
         if ((i % 2) == 0) DI = ramp(100 + i / 2);
         tick();
         if ((i / 2 + 1) >= 3) begin
            chk("t3_vo", 32'(VO), 32'h1);
            chk("t3_do", 32'(DO), 32'(ramp(100 + i / 2 + 1 - 3)));
         end else begin
            chk("t3_vo_low", 32'(VO), 32'h0);
         end
      end

      // T4: reduce delay to 2 while streaming
      CE = 1'b1; VI = 1'b1; Dly = 5'd2; Dly_ld = 1'b1; DI = ramp(200);
      tick();
      Dly_ld = 1'b0;
      chk("t4_ld_rdy", 32'(Rdy), 32'h0);
      chk("t4_ld_vo", 32'(VO), 32'h0);
      DI = ramp(201);
      tick();
      chk("t4_c1_rdy", 32'(Rdy), 32'h0);
      chk("t4_c1_vo", 32'(VO), 32'h0);
      DI = ramp(202);
      tick();
      chk("t4_c2_rdy", 32'(Rdy), 32'h1);
      chk("t4_c2_vo", 32'(VO), 32'h1);
      chk("t4_c2_do", 32'(DO), 32'(ramp(201)));
      DI = ramp(203);
      tick();
      chk("t4_c3_do", 32'(DO), 32'(ramp(202)));

      // T4: delay 0 is a combinational bypass
      CE = 1'b0; Dly = 5'd0; Dly_ld = 1'b1;
      tick();
      Dly_ld = 1'b0;
      DI = 16'h1234; VI = 1'b1;
      #1;
      chk("t4_byp_do", 32'(DO), 32'h1234);
      chk("t4_byp_vo", 32'(VO), 32'h1);
      chk("t4_byp_rdy", 32'(Rdy), 32'h1);
      DI = 16'hbeef; VI = 1'b0;
      #1;
      chk("t4_byp_do2", 32'(DO), 32'hbeef);
      chk("t4_byp_vo2", 32'(VO), 32'h0);

      // T5: overrange load clamps to DN and sets the sticky error
      CE = 1'b0; Dly = 5'd20; Dly_ld = 1'b1;
      tick();
      Dly_ld = 1'b0;
      chk("t5_err", 32'(Dly_err), 32'h1);
      chk("t5_rdy", 32'(Rdy), 32'h0);
      CE = 1'b1; VI = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         DI = ramp(50 + j);
         tick();
         if (j < 16) begin
            chk("t5_fill_rdy", 32'(Rdy), 32'h0);
         end else begin
            chk("t5_full_rdy", 32'(Rdy), 32'h1);
            chk("t5_full_vo", 32'(VO), 32'h1);
            chk("t5_full_do", 32'(DO), 32'(ramp(51)));
         end
      end
      Flush = 1'b1; DI = ramp(67);
      tick();
      Flush = 1'b0;
      chk("t5_fl_vo", 32'(VO), 32'h0);
      chk("t5_fl_rdy", 32'(Rdy), 32'h0);
      chk("t5_fl_do", 32'(DO), 32'(ramp(52)));
      for (int j = 1; j <= 16; j++) begin
         DI = ramp(67 + j);
         tick();
         if (j < 16) begin
            chk("t5_rf_vo", 32'(VO), 32'h0);
         end else begin
            chk("t5_rf_rdy", 32'(Rdy), 32'h1);
            chk("t5_rf_vo1", 32'(VO), 32'h1);
            chk("t5_rf_do", 32'(DO), 32'(ramp(68)));
         end
      end
      chk("t5_err_sticky", 32'(Dly_err), 32'h1);

      // T6: flush, load and shift on the same edge
      Flush = 1'b1; Dly_ld = 1'b1; Dly = 5'd2; CE = 1'b1; VI = 1'b1; DI = ramp(90);
      tick();
      Flush = 1'b0; Dly_ld = 1'b0;
      chk("t6_rdy", 32'(Rdy), 32'h0);
      chk("t6_vo", 32'(VO), 32'h0);
      chk("t6_err", 32'(Dly_err), 32'h1);
      DI = ramp(91);
      tick();
      chk("t6_c1_rdy", 32'(Rdy), 32'h0);
      DI = ramp(92);
      tick();
      chk("t6_c2_rdy", 32'(Rdy), 32'h1);
      chk("t6_c2_vo", 32'(VO), 32'h1);
      chk("t6_c2_do", 32'(DO), 32'(ramp(91)));

      // T6: asynchronous reset between clock edges
      Rst = 1'b1;
      #2;
      chk("t6_rst_do", 32'(DO), 32'h0);
      chk("t6_rst_vo", 32'(VO), 32'h0);
      chk("t6_rst_rdy", 32'(Rdy), 32'h0);
      chk("t6_rst_err", 32'(Dly_err), 32'h0);
      Rst = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         DI = ramp(120 + j);
         tick();
         chk("t6_re_rdy", 32'(Rdy), (j == 6) ? 32'h1 : 32'h0);
         chk("t6_re_vo", 32'(VO), (j == 6) ? 32'h1 : 32'h0);
         chk("t6_re_do", 32'(DO), (j == 6) ? 32'(ramp(121)) : 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
